// File: rtl/axi4_lite_gpu_cmdq.sv
// AXI4-Lite control slave feeding a command FIFO towards the GPU decoder.
// Registers: CMD_PUSH (0x00), STATUS (0x04), CTRL (0x08), SCRATCH (0x0C).
module axi4_lite_gpu_cmdq #(
    parameter int AXI_ADDRESS_WIDTH = 32,
    parameter int AXI_DATA_WIDTH    = 32,
    parameter int CMD_FIFO_DEPTH    = 16,
    parameter int LEVEL_WIDTH       = $clog2(CMD_FIFO_DEPTH) + 1
) (
    input  logic                          s_axi_ctrl_aclk,
    input  logic                          s_axi_ctrl_areset,
    input  logic [AXI_ADDRESS_WIDTH-1:0]  s_axi_ctrl_awaddr,
    input  logic                          s_axi_ctrl_awvalid,
    output logic                          s_axi_ctrl_awready,
    input  logic [AXI_DATA_WIDTH-1:0]     s_axi_ctrl_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_ctrl_wstrb,
    input  logic                          s_axi_ctrl_wvalid,
    output logic                          s_axi_ctrl_wready,
    output logic [1:0]                    s_axi_ctrl_bresp,
    output logic                          s_axi_ctrl_bvalid,
    input  logic                          s_axi_ctrl_bready,
    input  logic [AXI_ADDRESS_WIDTH-1:0]  s_axi_ctrl_araddr,
    input  logic                          s_axi_ctrl_arvalid,
    output logic                          s_axi_ctrl_arready,
    output logic [AXI_DATA_WIDTH-1:0]     s_axi_ctrl_rdata,
    output logic [1:0]                    s_axi_ctrl_rresp,
    output logic                          s_axi_ctrl_rvalid,
    input  logic                          s_axi_ctrl_rready,
    output logic [AXI_DATA_WIDTH-1:0]     cmd_data,
    output logic                          cmd_valid,
    input  logic                          cmd_ready
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(CMD_FIFO_DEPTH);
    localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(CMD_FIFO_DEPTH);
    localparam logic [15:0] ADDR_PUSH    = 16'h0000;
    localparam logic [15:0] ADDR_STATUS  = 16'h0004;
    localparam logic [15:0] ADDR_CTRL    = 16'h0008;
    localparam logic [15:0] ADDR_SCRATCH = 16'h000C;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;

    logic                      ready_en_q;
    logic                      aw_held_q;
    logic [15:0]               aw_addr_q;
    logic                      w_held_q;
    logic [AXI_DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]         w_strb_q;
    logic                      bvalid_q;
    logic [1:0]                bresp_q;
    logic                      rvalid_q;
    logic [1:0]                rresp_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic [AXI_DATA_WIDTH-1:0] fifo_mem [CMD_FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q;
    logic [PTR_W-1:0]          rd_ptr_q;
    logic [LEVEL_WIDTH-1:0]    level_q;
    logic                      overflow_q;
    logic [AXI_DATA_WIDTH-1:0] scratch_q;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      do_write;
    logic                      strb_all;
    logic                      push;
    logic                      pop;
    logic                      flush;
    logic                      ovf_set;
    logic                      ovf_clr;
    logic [1:0]                wr_resp;
    logic [AXI_DATA_WIDTH-1:0] status_word;
    logic [AXI_DATA_WIDTH-1:0] rd_data_next;
    logic [1:0]                rd_resp_next;
    logic                      unused_addr_hi;

    // Only the low 16 address bits are decoded.
    assign unused_addr_hi = ^{s_axi_ctrl_awaddr[AXI_ADDRESS_WIDTH-1:16],
                              s_axi_ctrl_araddr[AXI_ADDRESS_WIDTH-1:16]};

    assign fifo_full  = (level_q == FULL_LEVEL);
    assign fifo_empty = (level_q == '0);
    assign do_write   = aw_held_q && w_held_q && !bvalid_q;
    assign strb_all   = &w_strb_q;
    assign push       = do_write && (aw_addr_q == ADDR_PUSH) && strb_all && !fifo_full;
    assign ovf_set    = do_write && (aw_addr_q == ADDR_PUSH) && fifo_full;
    assign flush      = do_write && (aw_addr_q == ADDR_CTRL) && w_strb_q[0] && w_data_q[0];
    assign ovf_clr    = do_write && (aw_addr_q == ADDR_CTRL) && w_strb_q[0] && w_data_q[1];
    assign pop        = !fifo_empty && cmd_ready;

    assign s_axi_ctrl_awready = ready_en_q && !aw_held_q && !bvalid_q;
    assign s_axi_ctrl_wready  = ready_en_q && !w_held_q && !bvalid_q;
    assign s_axi_ctrl_arready = ready_en_q && !rvalid_q;
    assign s_axi_ctrl_bvalid  = bvalid_q;
    assign s_axi_ctrl_bresp   = bresp_q;
    assign s_axi_ctrl_rvalid  = rvalid_q;
    assign s_axi_ctrl_rresp   = rresp_q;
    assign s_axi_ctrl_rdata   = rdata_q;
    assign cmd_valid          = !fifo_empty;
    assign cmd_data           = fifo_mem[rd_ptr_q];

    // Write response for the transaction being performed this cycle.
    always_comb begin
        wr_resp = RESP_SLVERR;
        case (aw_addr_q)
            ADDR_PUSH:    wr_resp = (strb_all && !fifo_full) ? RESP_OKAY : RESP_SLVERR;
            ADDR_CTRL:    wr_resp = RESP_OKAY;
            ADDR_SCRATCH: wr_resp = RESP_OKAY;
            default:      wr_resp = RESP_SLVERR;
        endcase
    end

    // STATUS word assembled from the live FIFO state.
    always_comb begin
        status_word = '0;
        status_word[LEVEL_WIDTH-1:0] = level_q;
        status_word[16] = fifo_full;
        status_word[17] = fifo_empty;
        status_word[18] = overflow_q;
    end

    // Read data/response selected by the presented read address.
    always_comb begin
        rd_data_next = '0;
        rd_resp_next = RESP_OKAY;
        case (s_axi_ctrl_araddr[15:0])
            ADDR_STATUS:  rd_data_next = status_word;
            ADDR_CTRL:    rd_data_next = '0;
            ADDR_SCRATCH: rd_data_next = scratch_q;
            default:      rd_resp_next = RESP_SLVERR;
        endcase
    end

    // AXI channel holding registers and response generation.
    always_ff @(posedge s_axi_ctrl_aclk or posedge s_axi_ctrl_areset) begin
        if (s_axi_ctrl_areset) begin
            ready_en_q <= 1'b0;
            aw_held_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            rvalid_q   <= 1'b0;
            rresp_q    <= '0;
            rdata_q    <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (s_axi_ctrl_awready && s_axi_ctrl_awvalid) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= s_axi_ctrl_awaddr[15:0];
            end
            if (s_axi_ctrl_wready && s_axi_ctrl_wvalid) begin
                w_held_q <= 1'b1;
                w_data_q <= s_axi_ctrl_wdata;
                w_strb_q <= s_axi_ctrl_wstrb;
            end
            if (do_write) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (bvalid_q && s_axi_ctrl_bready) begin
                bvalid_q  <= 1'b0;
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end
            if (s_axi_ctrl_arready && s_axi_ctrl_arvalid) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data_next;
                rresp_q  <= rd_resp_next;
            end else if (rvalid_q && s_axi_ctrl_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // FIFO pointers, fill level and overflow sticky bit; flush overrides any pop.
    always_ff @(posedge s_axi_ctrl_aclk or posedge s_axi_ctrl_areset) begin
        if (s_axi_ctrl_areset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                if (push && !pop)      level_q <= level_q + LEVEL_WIDTH'(1);
                else if (pop && !push) level_q <= level_q - LEVEL_WIDTH'(1);
            end
            if (ovf_set)      overflow_q <= 1'b1;
            else if (ovf_clr) overflow_q <= 1'b0;
        end
    end

    // FIFO storage; contents need no reset since level gates visibility.
    always_ff @(posedge s_axi_ctrl_aclk) begin
        if (push) fifo_mem[wr_ptr_q] <= w_data_q;
    end

    // SCRATCH register with per-byte write enables.
    always_ff @(posedge s_axi_ctrl_aclk or posedge s_axi_ctrl_areset) begin
        if (s_axi_ctrl_areset) begin
            scratch_q <= '0;
        end else if (do_write && (aw_addr_q == ADDR_SCRATCH)) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (w_strb_q[i]) scratch_q[i*8 +: 8] <= w_data_q[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_gpu_cmdq.sv
// Self-checking bench for axi4_lite_gpu_cmdq: directed scenarios plus a
// randomized register/FIFO phase checked against a queue-based model.
module tb_axi4_lite_gpu_cmdq;

    logic        clk;
    logic        rst;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] q[$];
    logic        ovf = 1'b0;
    logic [31:0] scratch = '0;

    axi4_lite_gpu_cmdq #(
        .AXI_ADDRESS_WIDTH(32),
        .AXI_DATA_WIDTH(32),
        .CMD_FIFO_DEPTH(16)
    ) dut (
        .s_axi_ctrl_aclk   (clk),
        .s_axi_ctrl_areset (rst),
        .s_axi_ctrl_awaddr (awaddr),
        .s_axi_ctrl_awvalid(awvalid),
        .s_axi_ctrl_awready(awready),
        .s_axi_ctrl_wdata  (wdata),
        .s_axi_ctrl_wstrb  (wstrb),
        .s_axi_ctrl_wvalid (wvalid),
        .s_axi_ctrl_wready (wready),
        .s_axi_ctrl_bresp  (bresp),
        .s_axi_ctrl_bvalid (bvalid),
        .s_axi_ctrl_bready (bready),
        .s_axi_ctrl_araddr (araddr),
        .s_axi_ctrl_arvalid(arvalid),
        .s_axi_ctrl_arready(arready),
        .s_axi_ctrl_rdata  (rdata),
        .s_axi_ctrl_rresp  (rresp),
        .s_axi_ctrl_rvalid (rvalid),
        .s_axi_ctrl_rready (rready),
        .cmd_data          (cmd_data),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = '0;
        s[4:0] = 5'(q.size());
        s[16]  = (q.size() == 16);
        s[17]  = (q.size() == 0);
        s[18]  = ovf;
        return s;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp);
        resp = 2'b10;
        case (addr[15:0])
            16'h0000: begin
                if (q.size() == 16) ovf = 1'b1;
                else if (strb == 4'hF) begin
                    q.push_back(data);
                    resp = 2'b00;
                end
            end
            16'h0008: begin
                resp = 2'b00;
                if (strb[0]) begin
                    if (data[0]) q.delete();
                    if (data[1]) ovf = 1'b0;
                end
            end
            16'h000C: begin
                resp = 2'b00;
                for (int i = 0; i < 4; i++)
                    if (strb[i]) scratch[i*8 +: 8] = data[i*8 +: 8];
            end
            default: ;
        endcase
    endtask

    task automatic model_read(input logic [31:0] addr, output logic [31:0] data,
                              output logic [1:0] resp);
        data = '0;
        resp = 2'b00;
        case (addr[15:0])
            16'h0004: data = model_status();
            16'h0008: data = '0;
            16'h000C: data = scratch;
            default:  resp = 2'b10;
        endcase
    endtask

    // Command stream monitor: every pop must deliver the model's oldest entry.
    always @(negedge clk) begin
        if (!rst && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            check("cmd_pop_has_entry", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                check("cmd_data_order", cmd_data, q[0]);
                void'(q.pop_front());
            end
        end
    end

    // Issue AW and W with independent random delays, then collect B.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int  ad, wd;
        bit  aw_done, w_done, aw_hs, w_hs, got;
        ad = $urandom_range(0, 2);
        wd = $urandom_range(0, 2);
        aw_done = 0; w_done = 0; got = 0;
        resp = 2'bxx;
        awaddr = addr; wdata = data; wstrb = strb;
        for (int c = 0; c < 30 && !(aw_done && w_done); c++) begin
            awvalid = !aw_done && (c >= ad);
            wvalid  = !w_done && (c >= wd);
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
        end
        awvalid = 0; wvalid = 0;
        check("aw_w_accepted", 32'(aw_done && w_done), 32'd1);
        bready = 1;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (bvalid) begin
                resp = bresp;
                got = 1;
            end
            @(posedge clk); #1;
        end
        bready = 0;
        check("b_received", 32'(got), 32'd1);
    endtask

    task automatic wr_check(input string tag, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        logic [1:0] exp, act;
        model_write(addr, data, strb, exp);
        axi_write(addr, data, strb, act);
        check(tag, 32'(act), 32'(exp));
    endtask

    task automatic axi_read(input logic [31:0] addr, input int hold,
                            output logic [31:0] data, output logic [1:0] resp);
        bit done, hs;
        done = 0;
        araddr = addr;
        arvalid = 1;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            hs = arready;
            @(posedge clk); #1;
            if (hs) done = 1;
        end
        arvalid = 0;
        check("ar_accepted", 32'(done), 32'd1);
        check("rvalid_next_cycle", 32'(rvalid), 32'd1);
        data = rdata;
        resp = rresp;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("rvalid_held", 32'(rvalid), 32'd1);
            check("rdata_stable", rdata, data);
            check("rresp_stable", 32'(rresp), 32'(resp));
        end
        rready = 1;
        @(posedge clk); #1;
        rready = 0;
        check("rvalid_cleared", 32'(rvalid), 32'd0);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr, input int hold);
        logic [31:0] ed, ad;
        logic [1:0]  er, ar;
        model_read(addr, ed, er);
        axi_read(addr, hold, ad, ar);
        check({tag, "_data"}, ad, ed);
        check({tag, "_resp"}, 32'(ar), 32'(er));
    endtask

    task automatic drain();
        cmd_ready = 1;
        for (int c = 0; c < 60 && q.size() > 0; c++) begin
            @(posedge clk); #1;
        end
        cmd_ready = 0;
        check("drain_model_empty", 32'(q.size()), 32'd0);
        check("drain_cmd_valid", 32'(cmd_valid), 32'd0);
    endtask

    logic [31:0] d, a;
    logic [1:0]  r;
    logic [3:0]  s;
    logic [31:0] addr_pool [8];

    initial begin
        rst = 1; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
        bready = 0; araddr = '0; arvalid = 0; rready = 0; cmd_ready = 0;

        // Reset values, before any clock edge
        #1;
        check("rst_readies", {29'd0, awready, wready, arready}, 32'd0);
        check("rst_valids", {29'd0, bvalid, rvalid, cmd_valid}, 32'd0);
        check("rst_resps", {28'd0, bresp, rresp}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        repeat (3) @(posedge clk);
        #3 rst = 0;
        @(posedge clk); #1;
        check("post_rst_readies", {29'd0, awready, wready, arready}, 32'h7);

        // AW first, W three cycles later, partial strobe to SCRATCH
        awaddr = 32'h0000_000C; awvalid = 1;
        @(negedge clk);
        check("req22_awready", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 0;
        repeat (2) @(posedge clk);
        #1;
        wdata = 32'hA5A5_A5A5; wstrb = 4'b0011; wvalid = 1;
        @(negedge clk);
        check("req22_wready", 32'(wready), 32'd1);
        @(posedge clk); #1;
        wvalid = 0;
        check("req22_bvalid_not_yet", 32'(bvalid), 32'd0);
        @(posedge clk); #1;
        check("req22_bvalid", 32'(bvalid), 32'd1);
        check("req22_bresp", 32'(bresp), 32'd0);
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
        check("req22_b_done", 32'(bvalid), 32'd0);
        scratch[15:0] = 16'hA5A5;
        axi_read(32'h0000_000C, 0, d, r);
        check("req22_scratch", d, 32'h0000_A5A5);

        // Fill to 16, then overflow
        for (int i = 0; i < 16; i++) wr_check("req23_push_ok", 32'h0, $urandom(), 4'hF);
        axi_read(32'h4, 0, d, r);
        check("req23_status_full", d, 32'h0001_0010);
        wr_check("req23_push_full", 32'h0, 32'hDEAD_BEEF, 4'hF);
        axi_read(32'h4, 0, d, r);
        check("req23_status_ovf", d, 32'h0005_0010);
        check("req23_head_unchanged", cmd_data, q[0]);

        // Pop 11 to leave 5, then flush and clear overflow in the same cycle as a pop
        cmd_ready = 1;
        repeat (11) @(posedge clk);
        #1;
        cmd_ready = 0;
        check("req25_level5", model_status(), 32'h0004_0005);
        rd_check("req25_status_pre", 32'h4, 0);
        awaddr = 32'h8; wdata = 32'h3; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(negedge clk);
        check("req25_aw_w_ready", {30'd0, awready, wready}, 32'h3);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; cmd_ready = 1;
        check("req25_valid_before", 32'(cmd_valid), 32'd1);
        @(posedge clk); #1;
        cmd_ready = 0;
        q.delete();
        ovf = 0;
        check("req25_cmd_valid", 32'(cmd_valid), 32'd0);
        check("req25_bvalid", 32'(bvalid), 32'd1);
        check("req25_bresp", 32'(bresp), 32'd0);
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
        axi_read(32'h4, 0, d, r);
        check("req25_status", d, 32'h0002_0000);
        axi_read(32'h8, 0, d, r);
        check("req25_ctrl_reads_0", d, 32'd0);

        // Streaming with cmd_ready=1
        cmd_ready = 1;
        wr_check("req24_push11", 32'h0, 32'h11, 4'hF);
        wr_check("req24_push22", 32'h0, 32'h22, 4'hF);
        drain();
        axi_read(32'h4, 0, d, r);
        check("req24_status", d, 32'h0002_0000);

        // Unmapped read with back-pressure
        axi_read(32'h40, 4, d, r);
        check("req26_rdata", d, 32'd0);
        check("req26_rresp", 32'(r), 32'h2);

        // Randomized register traffic against the model
        addr_pool[0] = 32'h0; addr_pool[1] = 32'h0; addr_pool[2] = 32'h4;
        addr_pool[3] = 32'h8; addr_pool[4] = 32'hC; addr_pool[5] = 32'h10;
        addr_pool[6] = 32'h2; addr_pool[7] = 32'h40;
        for (int i = 0; i < 60; i++) begin
            a = addr_pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) == 0) begin
                d = $urandom();
                a[31:16] = d[31:16];
            end
            d = $urandom();
            s = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'hF;
            if (a[15:0] == 16'h8 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
            if ($urandom_range(0, 2) == 0) rd_check("rand_read", a, $urandom_range(0, 2));
            else wr_check("rand_write_resp", a, d, s);
        end
        rd_check("rand_status", 32'h4, 0);
        rd_check("rand_scratch", 32'hC, 0);
        drain();
        wr_check("rand_ctrl_clear", 32'h8, 32'h2, 4'h1);
        rd_check("rand_status_end", 32'h4, 0);

        // Reset while a B response is pending with 3 entries queued
        for (int i = 0; i < 3; i++) wr_check("req27_push", 32'h0, $urandom(), 4'hF);
        awaddr = 32'hC; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        @(posedge clk); #1;
        check("req27_bvalid_pending", 32'(bvalid), 32'd1);
        #1 rst = 1;
        #1;
        check("req27_bvalid_dropped", 32'(bvalid), 32'd0);
        check("req27_cmd_valid", 32'(cmd_valid), 32'd0);
        check("req27_readies", {29'd0, awready, wready, arready}, 32'd0);
        q.delete(); ovf = 0; scratch = '0;
        repeat (2) @(posedge clk);
        #3 rst = 0;
        bready = 1;
        @(posedge clk); #1;
        check("req27_readies_up", {29'd0, awready, wready, arready}, 32'h7);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("req27_no_b_beat", 32'(bvalid), 32'd0);
        end
        bready = 0;
        axi_read(32'h4, 0, d, r);
        check("req27_status", d, 32'h0002_0000);
        rd_check("req27_scratch", 32'hC, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
